// File: rtl/mat_arb_pkg.sv
// Shared definitions for the matrix-RAM arbiter: requester IDs, FSM encoding
// and default geometry.
package mat_arb_pkg;

    localparam int NREQ_DEF    = 4;
    localparam int AW_DEF      = 10;
    localparam int DW_DEF      = 8;
    localparam int TIMEOUT_DEF = 1024;

    localparam int REQ_INPUT = 0;
    localparam int REQ_GEN   = 1;
    localparam int REQ_DISP  = 2;
    localparam int REQ_OP    = 3;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mat_mem_arbiter_if.sv
// Client-side bus of the matrix-RAM arbiter: flattened per-requester request
// lanes plus the shared grant/read-return signals.
interface mat_mem_arbiter_if
    import mat_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) ();

    // Handshake: requester i issues one beat in every cycle where req[i] and
    // gnt[i] are both high; lock[i] keeps gnt[i] across cycles with req[i]
    // low. A read beat is answered by rvalid[i] with rdata the next cycle.
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;

    modport master (
        output req, lock, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, lock, we, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first active request after last_owner,
// wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_owner,
    output logic [IW-1:0]   winner,
    output logic            found
);

    logic [IW-1:0] cand;

    // Scan from farthest to nearest so the nearest active requester wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = IW'((int'(last_owner) + i) % NREQ);
            if (req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mat_mem_arbiter.sv
// Round-robin owner of the single-port matrix RAM with 1-cycle read return.
// Define ARB_TIMEOUT_EN to build the grant watchdog (arb_timeout pulse).
module mat_mem_arbiter
    import mat_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    mat_mem_arbiter_if.slave  cli,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    output logic              busy,
    output logic              arb_timeout,
    output arb_state_e        state_dbg
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e    state_q, state_d;
    logic [IW-1:0] owner_q, last_owner_q, winner;
    logic          found;
    logic [NREQ-1:0] gnt_q, rvalid_q;
    logic          own_req, own_lock, own_we, timeout_hit;
    logic [AW-1:0] mux_addr;
    logic [DW-1:0] mux_wdata;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req        (cli.req),
        .last_owner (last_owner_q),
        .winner     (winner),
        .found      (found)
    );

    always_comb begin
        own_req   = 1'b0;
        own_lock  = 1'b0;
        own_we    = 1'b0;
        mux_addr  = '0;
        mux_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == owner_q) begin
                own_req   = cli.req[i];
                own_lock  = cli.lock[i];
                own_we    = cli.we[i];
                mux_addr  = cli.addr[i*AW +: AW];
                mux_wdata = cli.wdata[i*DW +: DW];
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] hold_q;

    // Counts GRANT cycles; reads 0 in the first cycle of every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if (state_q != ARB_GRANT) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == ARB_GRANT) && (hold_q == CW'(TIMEOUT - 1));
`else
    localparam int unused_timeout = TIMEOUT;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE:    if (found) state_d = ARB_GRANT;
            ARB_GRANT:   if (timeout_hit || (!own_req && !own_lock)) state_d = ARB_RELEASE;
            ARB_RELEASE: state_d = ARB_IDLE;
            default:     state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            owner_q      <= '0;
            last_owner_q <= IW'(NREQ - 1);
            gnt_q        <= '0;
            rvalid_q     <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= '0;
            if (mem_en && !mem_we) rvalid_q[owner_q] <= 1'b1;
            if ((state_q == ARB_IDLE) && found) begin
                owner_q      <= winner;
                last_owner_q <= winner;
                gnt_q        <= NREQ'(1) << winner;
            end else if (state_d != ARB_GRANT) begin
                gnt_q <= '0;
            end
        end
    end

    assign mem_en    = (state_q == ARB_GRANT) && own_req;
    assign mem_we    = mem_en && own_we;
    assign mem_addr  = (state_q == ARB_GRANT) ? mux_addr  : '0;
    assign mem_wdata = (state_q == ARB_GRANT) ? mux_wdata : '0;

    // The RAM output is already registered, so it is forwarded only in the
    // return cycle; outside it rdata stays 0.
    assign cli.gnt    = gnt_q;
    assign cli.rvalid = rvalid_q;
    assign cli.rdata  = (|rvalid_q) ? mem_rdata : '0;

    assign busy        = (state_q != ARB_IDLE);
    assign arb_timeout = timeout_hit;
    assign state_dbg   = state_q;

endmodule
